// File: rtl/tern_pkg.sv
// Shared types and constants for the ternary vector feeder.
// Holds the weight encodings, the datapath widths and the FSM state type.
package tern_pkg;

  localparam int ACT_W = 8;
  localparam int SUM_W = 20;

  localparam logic [1:0] W_ZERO = 2'b00;
  localparam logic [1:0] W_POS  = 2'b01;
  localparam logic [1:0] W_NEG  = 2'b11;
  localparam logic [1:0] W_RSVD = 2'b10;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Negation of a two's-complement int8 that clamps -128 to +127.
  function automatic logic signed [ACT_W-1:0] sat_neg(input logic signed [ACT_W-1:0] a);
    logic signed [ACT_W-1:0] r;
    if (a == {1'b1, {(ACT_W-1){1'b0}}}) r = {1'b0, {(ACT_W-1){1'b1}}};
    else                                 r = -a;
    return r;
  endfunction

endpackage

// File: rtl/tern_mult_lane.sv
// One lane of the ternary multiply: int8 activation times {-1, 0, +1}.
// The reserved code behaves like zero so a corrupt weight cannot bias the sum.
module tern_mult_lane
  import tern_pkg::*;
(
  input  logic signed [ACT_W-1:0] act,
  input  logic        [1:0]       wt,
  output logic signed [ACT_W-1:0] prod
);

  always_comb begin
    prod = '0;
    case (wt)
      W_POS:   prod = act;
      W_NEG:   prod = sat_neg(act);
      default: prod = '0;
    endcase
  end

endmodule

// File: rtl/tern_vector_feeder.sv
// Stages ternary products into a bank that feeds the adder tree, waits out the
// tree latency after the final beat, then holds the tree sum on a valid/ready port.
module tern_vector_feeder
  import tern_pkg::*;
#(
  parameter int DEPTH        = 4096,
  parameter int LANES        = 8,
  parameter int TREE_LATENCY = 12,
  parameter int SUM_W        = 20
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*ACT_W-1:0]   in_act,
  input  logic [LANES*2-1:0]       in_wt,
  input  logic                     in_last,
  output logic [DEPTH*ACT_W-1:0]   prod_bank,
  input  logic [SUM_W-1:0]         tree_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SUM_W-1:0]         out_sum
);

  localparam int NBEATS = DEPTH / LANES;
  localparam int IDX_W  = $clog2(DEPTH + 1);
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int CNT_W  = (TREE_LATENCY > 1) ? $clog2(TREE_LATENCY) : 1;

  state_e                              state, state_nxt;
  logic [IDX_W-1:0]                    wr_idx;
  logic [BEAT_W-1:0]                   wr_beat;
  logic [CNT_W-1:0]                    wait_cnt;
  logic [NBEATS-1:0][LANES*ACT_W-1:0]  bank;
  logic [LANES-1:0][ACT_W-1:0]         prod;
  logic                                acc, vec_end, cap, drain;

  tern_mult_lane u_lane [LANES-1:0] (
    .act  (in_act),
    .wt   (in_wt),
    .prod (prod)
  );

  assign acc       = in_valid & in_ready;
  assign wr_beat   = BEAT_W'(wr_idx / IDX_W'(LANES));
  assign prod_bank = bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    vec_end   = 1'b0;
    cap       = 1'b0;
    drain     = 1'b0;
    case (state)
      FILL: begin
        // in_last and a full bank on the same beat collapse into one end event
        if (acc && (in_last || wr_idx == IDX_W'(DEPTH - LANES))) begin
          vec_end   = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          cap       = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          drain     = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Registered so in_ready never sees in_valid or out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_ready <= 1'b1;
    else        in_ready <= (state_nxt == FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx   <= '0;
      wait_cnt <= '0;
    end else begin
      if (drain)    wr_idx <= '0;
      else if (acc) wr_idx <= wr_idx + IDX_W'(LANES);
      if (vec_end)                           wait_cnt <= CNT_W'(TREE_LATENCY - 1);
      else if (state == WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // Clearing on the way back to FILL is what keeps short vectors zero-padded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= '0;
    end else if (drain) begin
      bank <= '0;
    end else if (acc) begin
      for (int b = 0; b < NBEATS; b++)
        if (wr_beat == BEAT_W'(b)) bank[b] <= prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (cap) begin
      out_valid <= 1'b1;
      out_sum   <= tree_sum;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/tern_vector_feeder.md
# tern_vector_feeder

Front end of the BitNet 1.58 vector–ternary multiply layer, and the producer side of the pipelined adder tree. Accepts a stream of int8 activations paired with 2-bit ternary weights, applies the ternary multiply per element, and stages the products in a DEPTH-entry bank wired to the tree's parallel input. After the last element, it waits out the tree's pipeline latency, captures the tree's 20-bit sum, and presents it on a valid/ready output.

## Interface
- DEPTH, 4096: elements per vector; equals the tree input count; must be a multiple of LANES.
- LANES, 8: elements accepted per input beat.
- TREE_LATENCY, 12: registered stages in the tree, log2(DEPTH).
- SUM_W, 20: result width.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  feeder accepts a beat.
- in_act  in  LANES*8  signed int8 activations; lane k is bits [8k+7:8k].
- in_wt  in  LANES*2  ternary codes; lane k is bits [2k+1:2k].
- in_last  in  1  final beat of the vector.
- prod_bank  out  DEPTH*8  staged signed products to the tree; entry e is bits [8e+7:8e].
- tree_sum  in  SUM_W  signed result from the tree.
- out_valid  out  1  out_sum holds a result.
- out_ready  in  1  consumer takes the result.
- out_sum  out  SUM_W  signed vector dot product.

## Operation
- Weight codes: 2'b00 → 0; 2'b01 → +act; 2'b11 → −act; 2'b10 is reserved and yields product 0.
- Negating −128 saturates to +127. Every product is int8.
- States:
  - FILL: in_ready = 1. Each accepted beat (in_valid & in_ready) writes LANES products at entries [wr_idx, wr_idx+LANES−1], then wr_idx += LANES. The beat that has in_last = 1, or that fills the bank (wr_idx reaches DEPTH), moves the block to WAIT and loads wait_cnt = TREE_LATENCY−1. Whichever condition comes first ends the vector.
  - WAIT: in_ready = 0. The bank is held stable and wait_cnt decrements each cycle. At wait_cnt == 0, tree_sum is registered into out_sum, out_valid is set, and the block moves to HOLD.
  - HOLD: out_valid = 1 and out_sum is stable. When out_valid & out_ready, the next edge clears out_valid, clears the whole bank to 0, sets wr_idx = 0, and returns to FILL.
- Short vectors (in_last before the bank is full): entries not written stay 0, because the bank is cleared on entry to FILL. They contribute nothing to the sum.
- in_last on the beat that also fills the bank is a single end-of-vector event, not two.
- Reset, at any time including mid-WAIT: state goes to FILL; wr_idx, wait_cnt and the bank go to 0; out_valid = 0; out_sum = 0; in_ready = 1 once rst_n deasserts. Stale contents of the tree pipeline are harmless because the wait count restarts with the next vector.

## Timing
- Reset values: in_ready 1, out_valid 0, out_sum 0, prod_bank all 0.
- A beat accepted at edge t appears on prod_bank after edge t.
- Last beat accepted at edge t: out_sum is captured and out_valid rises at edge t+TREE_LATENCY.
- Throughput per vector: beats + TREE_LATENCY + HOLD cycles + 1. There is no overlap between vectors.
- in_ready is registered from state and never combinationally depends on in_valid.
- No path exists from out_ready to in_ready within the same cycle.

## Structure
- Shared package tern_pkg:
  - weight code constants W_ZERO, W_POS, W_NEG, W_RSVD;
  - ACT_W = 8, SUM_W = 20;
  - state enum FILL / WAIT / HOLD.
- Sub-module tern_mult_lane: combinational int8 × ternary multiply with saturation. The feeder instantiates it LANES times.
- The feeder holds the FSM, write index, wait counter, bank registers and output register.

## Test plan
Bench parameters are DEPTH=16, LANES=4, TREE_LATENCY=4, driving a behavioural registered tree model.
- All act = 1, wt = 01, 4 beats, last beat with in_last → out_sum = 16, and out_valid rises 4 cycles after the last accept.
- All act = −128, wt = 11 → every product is 127, out_sum = 2032. Same data with wt = 01 → out_sum = −2048.
- act = 5, wt = 01, in_last on beat 2 → entries 8–15 stay 0 and out_sum = 40. The following full vector of all 1s gives 16, which proves the bank was cleared.
- out_ready held low for 10 cycles in HOLD:
  - out_valid stays 1, out_sum is unchanged and in_ready stays 0;
  - on the handshake, in_ready = 1 on the next cycle.
- rst_n pulsed low for 1 cycle during WAIT → out_valid = 0, prod_bank = 0 and in_ready = 1. A fresh vector of all 1s then yields 16.
- Mixed codes 01/11/00/10 on act = 3 across all 16 entries → out_sum = 0. Each pair of +3/−3 cancels, and 00 and 10 contribute 0.
